// File: rtl/sparam_sweep_ctrl_pkg.sv
// Shared types for the two-port S-parameter sweep sequencer.
package sparam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        REQ,
        ADV,
        DONE
    } state_t;

    // Result tags are {rx_sel, src_port}.
    localparam logic [1:0] S11 = 2'b00;
    localparam logic [1:0] S21 = 2'b10;
    localparam logic [1:0] S12 = 2'b01;
    localparam logic [1:0] S22 = 2'b11;

endpackage

// File: rtl/sparam_sweep_ctrl_if.sv
// Source/receiver control and capture handshake between the sequencer and the detector front end.
interface sparam_sweep_ctrl_if;

    logic       src_en;
    logic       src_port;
    logic       rx_sel;
    logic       meas_req;
    logic       meas_ack;
    logic       res_valid;
    logic [1:0] res_sij;

    modport master (
        output src_en, src_port, rx_sel, meas_req, res_valid, res_sij,
        input  meas_ack
    );

    modport slave (
        input  src_en, src_port, rx_sel, meas_req, res_valid, res_sij,
        output meas_ack
    );

endinterface

// File: rtl/sparam_wait_cnt.sv
// Loadable down-counter with a zero flag, shared by the settle and ack-timeout phases.
module sparam_wait_cnt #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sparam_sweep_ctrl.sv
// Sweep sequencer: per frequency point excites P1 then P2 and captures both receivers for each source.
module sparam_sweep_ctrl
    import sparam_pkg::*;
#(
    parameter int FREQ_W      = 10,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [FREQ_W-1:0]   n_points,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [FREQ_W-1:0]   freq_idx,
    sparam_sweep_ctrl_if.master meas
);

    // Counter terminal count is load_val, so a load of N-1 gives N cycles.
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state;
    logic [FREQ_W-1:0] last_idx;
    logic              src_port;
    logic              rx_sel;
    logic              src_en;
    logic              meas_req;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_zero;

    sparam_wait_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = SETTLE_LOAD;
        case (state)
            IDLE:   cnt_load = start && (n_points != '0);
            SETTLE: begin
                cnt_load = cnt_zero;
                cnt_val  = TIMEOUT_LOAD;
            end
            ADV: begin
                cnt_load = 1'b1;
                if (rx_sel == 1'b0) cnt_val = TIMEOUT_LOAD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            freq_idx <= '0;
            last_idx <= '0;
            src_port <= 1'b0;
            rx_sel   <= 1'b0;
            src_en   <= 1'b0;
            meas_req <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            src_en   <= 1'b0;
            meas_req <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    error <= 1'b0;
                    if (n_points != '0) begin
                        last_idx <= n_points - 1'b1;
                        freq_idx <= '0;
                        src_port <= 1'b0;
                        rx_sel   <= 1'b0;
                        busy     <= 1'b1;
                        src_en   <= 1'b1;
                        state    <= SETTLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                SETTLE: if (cnt_zero) begin
                    meas_req <= 1'b1;
                    state    <= REQ;
                end
                REQ: begin
                    if (meas.meas_ack) begin
                        meas_req <= 1'b0;
                        state    <= ADV;
                    end else if (cnt_zero) begin
                        meas_req <= 1'b0;
                        error    <= 1'b1;
                        src_en   <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                ADV: begin
                    case ({rx_sel, src_port})
                        S11, S12: begin
                            rx_sel   <= 1'b1;
                            meas_req <= 1'b1;
                            state    <= REQ;
                        end
                        S21: begin
                            src_port <= 1'b1;
                            rx_sel   <= 1'b0;
                            state    <= SETTLE;
                        end
                        default: begin
                            if (freq_idx == last_idx) begin
                                src_en <= 1'b0;
                                done   <= 1'b1;
                                state  <= DONE;
                            end else begin
                                freq_idx <= freq_idx + 1'b1;
                                src_port <= 1'b0;
                                rx_sel   <= 1'b0;
                                state    <= SETTLE;
                            end
                        end
                    endcase
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result strobe is combinational so it coincides with the accepted ack.
    assign meas.src_en    = src_en;
    assign meas.src_port  = src_port;
    assign meas.rx_sel    = rx_sel;
    assign meas.meas_req  = meas_req;
    assign meas.res_valid = meas_req & meas.meas_ack;
    assign meas.res_sij   = {rx_sel, src_port};

endmodule
